// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: fetch FSM state encoding and constants shared by the fetch front end.
// No ports.
package fetch_unit_pkg;
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;
    localparam int INSN_BYTES = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_1000;
endpackage

// File: rtl/fetch_pc_next.sv
// fetch_pc_next: combinational next-PC mux (aligned redirect / sequential advance / hold).
// Ports: pc (current fetch PC), redirect_valid/redirect_pc (redirect target),
//        advance (step to the next instruction), pc_next (selected PC).
module fetch_pc_next #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc_next
);
    import fetch_unit_pkg::*;
    // Redirect targets are word-aligned by clearing the byte-offset bits; pc+4 wraps naturally.
    always_comb pc_next = redirect_valid ? (redirect_pc & ~XLEN'(INSN_BYTES - 1))
                        : advance        ? pc + XLEN'(INSN_BYTES)
                        : pc;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch front end with stall and redirect handling.
// Ports: clk/reset (async active-high); stall from IF/ID; redirect_valid/redirect_pc from execute;
//        icache_req/icache_addr request, icache_rvalid/icache_rdata response;
//        out_valid/out_pc/out_insn registered instruction presented to IF/ID.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              INSN_W   = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              icache_req,
    output logic [XLEN-1:0]   icache_addr,
    input  logic              icache_rvalid,
    input  logic [INSN_W-1:0] icache_rdata,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_pc,
    output logic [INSN_W-1:0] out_insn
);
    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic            kill, kill_next, take, drop;

    assign take = (state == S_WAIT) && icache_rvalid;
    // A response is stale if a redirect arrived while it was in flight or arrives with it.
    assign drop = kill || redirect_valid;

    fetch_pc_next #(.XLEN(XLEN)) u_pc_next (
        .pc             (pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (take && !drop),
        .pc_next        (pc_next)
    );

    // In S_REQ pc_next is the redirect-or-current PC, so a same-cycle redirect costs nothing.
    assign icache_req  = (state == S_REQ) && !reset;
    assign icache_addr = pc_next;

    always_comb begin
        state_next = state;
        kill_next  = kill;
        case (state)
            S_REQ:  state_next = S_WAIT;
            S_WAIT: begin
                kill_next = icache_rvalid ? 1'b0 : (kill || redirect_valid);
                if (icache_rvalid) state_next = drop ? S_REQ : S_HOLD;
            end
            S_HOLD: if (redirect_valid || !stall) state_next = S_REQ;
            default: state_next = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            kill      <= 1'b0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_insn  <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            kill  <= kill_next;
            if (take && !drop) begin
                out_valid <= 1'b1;
                out_pc    <= pc;
                out_insn  <= icache_rdata;
            end else if (state == S_HOLD && state_next == S_REQ) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a transaction-level reference model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_rvalid = 1'b0;
    logic [31:0] icache_rdata = '0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_insn;

    int pass = 0;
    int total = 0;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .icache_req     (icache_req),
        .icache_addr    (icache_addr),
        .icache_rvalid  (icache_rvalid),
        .icache_rdata   (icache_rdata),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_insn       (out_insn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) pass++;
        else $display("FAIL %s: got %h expected %h", n, a, e);
    endtask

    // Reference model: a request goes out whenever nothing is outstanding and nothing is held.
    logic        m_busy = 1'b0, m_dead = 1'b0, m_valid = 1'b0;
    logic [31:0] m_pc = 32'h1000, m_opc = '0, m_oinsn = '0;
    logic        exp_req;
    logic [31:0] exp_addr;
    assign exp_req  = !reset && !m_busy && !m_valid;
    assign exp_addr = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : m_pc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_dead = 0; m_valid = 0; m_pc = 32'h1000; m_opc = 0; m_oinsn = 0;
        end else if (exp_req) begin
            m_busy = 1; m_dead = 0; m_pc = exp_addr;
        end else if (m_busy) begin
            logic drop;
            drop = m_dead || redirect_valid;
            if (redirect_valid) begin m_pc = redirect_pc & 32'hFFFF_FFFC; m_dead = 1; end
            if (icache_rvalid) begin
                m_busy = 0;
                if (!drop) begin m_valid = 1; m_opc = m_pc; m_oinsn = icache_rdata; m_pc = m_pc + 32'd4; end
            end
        end else if (redirect_valid) begin
            m_valid = 0; m_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if (!stall) begin
            m_valid = 0;
        end
    end

    // Cache responder: answers each request lat cycles later with rsp_data.
    int          lat = 1;
    int          cd = 0;
    logic [31:0] rsp_data = 32'h0000_0013;
    logic        req_seen = 1'b0, prev_req = 1'b0;

    always @(posedge clk) begin
        #1;
        icache_rvalid = 1'b0;
        if (reset) cd = 0;
        else begin
            if (req_seen) cd = lat;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin icache_rvalid = 1'b1; icache_rdata = rsp_data; end
            end
        end
    end

    always @(negedge clk) begin
        chk("icache_req", {31'b0, icache_req}, {31'b0, exp_req});
        if (exp_req) chk("icache_addr", icache_addr, exp_addr);
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("out_pc", out_pc, m_opc);
        chk("out_insn", out_insn, m_oinsn);
        chk("req_b2b", {31'b0, icache_req && prev_req}, 32'd0);
        assert (!(icache_rvalid && !m_busy)) else $error("rvalid outside wait");
        prev_req = icache_req;
        req_seen = icache_req;
    end

    task automatic cyc(input logic s, input logic rv, input logic [31:0] rp);
        @(posedge clk); #1;
        stall = s; redirect_valid = rv; redirect_pc = rp;
        @(negedge clk);
    endtask

    task automatic lit_out(input logic v, input logic [31:0] p, input logic [31:0] i);
        chk("lit_valid", {31'b0, out_valid}, {31'b0, v});
        chk("lit_pc", out_pc, p);
        chk("lit_insn", out_insn, i);
    endtask

    task automatic lit_req(input logic [31:0] a);
        chk("lit_req", {31'b0, icache_req}, 32'd1);
        chk("lit_addr", icache_addr, a);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        lit_out(0, 0, 0);
        chk("lit_req_rst", {31'b0, icache_req}, 32'd0);
        @(posedge clk); #1; reset = 1'b0; @(negedge clk);
        lit_req(32'h1000);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        lit_out(1, 32'h1000, 32'h0000_0013);
        rsp_data = 32'hAAAA_0001;
        cyc(0, 0, 0);
        lit_req(32'h1004);
        cyc(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0);
            lit_out(1, 32'h1004, 32'hAAAA_0001);
            chk("lit_noreq", {31'b0, icache_req}, 32'd0);
        end
        cyc(0, 0, 0);
        lat = 4; rsp_data = 32'hDEAD_0000;
        cyc(0, 0, 0);
        lit_req(32'h1008);
        cyc(0, 1, 32'h2002);
        chk("lit_kill0", {31'b0, out_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            chk("lit_kill", {31'b0, out_valid}, 32'd0);
        end
        cyc(0, 0, 0);
        lit_req(32'h2000);
        chk("lit_dropped", {31'b0, out_valid}, 32'd0);
        lat = 1; rsp_data = 32'h1111_1111;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        lit_out(1, 32'h2000, 32'h1111_1111);
        rsp_data = 32'h2222_2222;
        cyc(0, 1, 32'h3000);
        lit_req(32'h3000);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        lit_out(1, 32'h3000, 32'h2222_2222);
        cyc(1, 1, 32'h4000);
        rsp_data = 32'h3333_3333;
        cyc(1, 0, 0);
        chk("lit_squash", {31'b0, out_valid}, 32'd0);
        lit_req(32'h4000);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        lit_out(1, 32'h4000, 32'h3333_3333);
        rsp_data = 32'h4444_4444;
        cyc(0, 1, 32'hFFFF_FFFC);
        lit_req(32'hFFFF_FFFC);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        lit_out(1, 32'hFFFF_FFFC, 32'h4444_4444);
        rsp_data = 32'h5555_5555;
        cyc(0, 0, 0);
        lit_req(32'h0000_0000);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        lit_out(1, 32'h0000_0000, 32'h5555_5555);
        lat = 100;
        cyc(0, 0, 0);
        lit_req(32'h0000_0004);
        cyc(0, 0, 0);
        #2 reset = 1'b1;
        #1 lit_out(0, 0, 0);
        chk("lit_req_arst", {31'b0, icache_req}, 32'd0);
        @(negedge clk);
        lat = 1; rsp_data = 32'h0000_0066;
        @(posedge clk); #1; reset = 1'b0; @(negedge clk);
        lit_req(32'h1000);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        lit_out(1, 32'h1000, 32'h0000_0066);
        cyc(0, 0, 0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of the core. Owns the PC, issues one instruction-cache read at a time, and presents {valid, pc, insn} to the IF/ID pipeline register directly downstream.
- Handles downstream stall and branch/jump redirect from execute, including killing an in-flight cache response.
- Single outstanding request, multicycle fetch: at most one instruction per 3 cycles.

Parameters:
- XLEN, 32, width of PC and addresses.
- INSN_W, 32, instruction width.
- RESET_PC, 32'h0000_1000, PC value loaded on reset.

Ports:
- clk  input  1  core clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  downstream (IF/ID) cannot accept this cycle.
- redirect_valid  input  1  take redirect_pc as the new fetch PC.
- redirect_pc  input  XLEN  redirect target; bits [1:0] forced to 0 internally.
- icache_req  output  1  read request strobe, one cycle per request.
- icache_addr  output  XLEN  request address, valid while icache_req=1.
- icache_rvalid  input  1  response strobe, one cycle, at least 1 cycle after icache_req.
- icache_rdata  input  INSN_W  response instruction, valid with icache_rvalid.
- out_valid  output  1  out_pc/out_insn hold a live instruction.
- out_pc  output  XLEN  PC of the presented instruction.
- out_insn  output  INSN_W  presented instruction.

Behaviour:
- Reset (asynchronous, active-high):
  - state=S_REQ, pc=RESET_PC, kill=0.
  - out_valid=0, out_pc=0, out_insn=0, icache_req=0.
  - The icache shares the same reset, so no stale response exists after reset.
  - Reset during S_WAIT abandons the request.
- States: S_REQ, S_WAIT, S_HOLD. All outputs are registered except icache_req and icache_addr, which are decoded from the current state.
- S_REQ:
  - icache_req=1; icache_addr = redirect_valid ? redirect_pc : pc.
  - pc<=icache_addr; next state S_WAIT.
  - A redirect in this cycle therefore costs no extra cycle.
- S_WAIT:
  - icache_req=0.
  - If redirect_valid: pc<=redirect_pc, kill<=1.
  - On icache_rvalid with (kill=1 or redirect_valid=1): drop the data, kill<=0, next S_REQ.
  - On icache_rvalid otherwise: out_valid<=1, out_pc<=pc, out_insn<=icache_rdata, pc<=pc+4, next S_HOLD.
  - With no rvalid: remain in S_WAIT indefinitely.
- S_HOLD:
  - out_* are held stable.
  - If redirect_valid: out_valid<=0, pc<=redirect_pc, next S_REQ. Redirect wins over stall and the held instruction is squashed.
  - Else if stall=0: the instruction is consumed this cycle (IF/ID captures it); out_valid<=0, next S_REQ.
  - Else: stay in S_HOLD with all outputs unchanged.
- Latency: request at cycle t, rvalid at t+k (k≥1), out_valid=1 from t+k+1. Minimum issue-to-issue time is 3 cycles.
- Arithmetic: pc+4 wraps modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000). No exception is raised.
- icache_rvalid in S_REQ or S_HOLD is a protocol violation. It is ignored; the bench asserts it never occurs.
- out_pc/out_insn keep their last value when out_valid=0. Consumers qualify on out_valid.
- Invariants:
  - Never more than one outstanding request.
  - icache_req never asserted in two consecutive cycles.

Decomposition:
- Shared package holds:
  - fetch state enum (S_REQ=2'd0, S_WAIT=2'd1, S_HOLD=2'd2);
  - INSN_BYTES=4;
  - default RESET_PC.
- One natural sub-module: fetch_pc_next, a combinational next-PC mux (redirect / pc+4 / hold, with alignment masking).
- State, pc, kill and out_* registers live in fetch_unit.

Test Plan:
- Reset release, cache answers k=1 with 0x00000013, stall=0 -> icache_addr=0x1000 in cycle 0; out_valid=1, out_pc=0x1000, out_insn=0x00000013 in cycle 2; next request addr 0x1004 in cycle 3.
- Response 0xAAAA0001 then stall=1 for 5 cycles -> out_valid/out_pc/out_insn stable for all 5 cycles, no icache_req; the request for pc+4 issues the cycle after stall falls.
- redirect_valid with pc=0x2002 during S_WAIT, response 0xDEAD0000 arrives 3 cycles later -> response dropped, out_valid stays 0; next icache_addr=0x2000.
- redirect 0x3000 in the same cycle as S_REQ -> icache_addr=0x3000 that cycle; subsequent out_pc=0x3000.
- redirect 0x4000 while in S_HOLD with stall=1 -> out_valid=0 next cycle, then icache_addr=0x4000.
- redirect_pc=0xFFFF_FFFC then sequential fetch -> out_pc=0xFFFF_FFFC, then 0x0000_0000; assert reset mid-S_WAIT -> out_valid=0 and pc=0x1000 immediately.
